// File: rtl/mrv1_csrf_mt_pkg.sv
// Shared types and CSR address map for the barrel-threaded mrv1 machine-mode CSR file.
package mrv1_csrf_mt_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // The 0xC00-0xFFF quadrant of the CSR space is read-only.
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/mrv1_csrf_mt_if.sv
// CSR access port: pipeline request (thread, address, op, operand) and old value / legality back.
interface mrv1_csrf_mt_if #(
  parameter int DATA_WIDTH_P = 32,
  parameter int TID_WIDTH_LP = 2
);
  import mrv1_csrf_mt_pkg::*;

  logic [TID_WIDTH_LP-1:0] tid;
  logic [11:0]             addr;
  csr_op_e                 op;
  logic [DATA_WIDTH_P-1:0] w_data;
  logic [DATA_WIDTH_P-1:0] r_data;
  logic                    illegal;

  modport master (output tid, addr, op, w_data, input r_data, illegal);
  modport slave  (input tid, addr, op, w_data, output r_data, illegal);

endinterface

// File: rtl/mrv1_csrf_mt_cnt64.sv
// 64-bit event counter with per-half CSR write; a write in a cycle suppresses that cycle's increment.
module mrv1_csrf_mt_cnt64 #(
  parameter int DATA_WIDTH_P = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    inc_i,
  input  logic                    wr_lo_i,
  input  logic                    wr_hi_i,
  input  logic [DATA_WIDTH_P-1:0] w_data_i,
  output logic [63:0]             count_o
);

  logic [63:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (wr_lo_i || wr_hi_i) begin
      // Untouched half holds; at 64-bit width the lo write covers the whole counter.
      if (wr_lo_i) cnt_reg[DATA_WIDTH_P-1:0] <= w_data_i;
      if (wr_hi_i) cnt_reg[63:32] <= w_data_i[31:0];
    end else if (inc_i) begin
      cnt_reg <= cnt_reg + 64'd1;
    end
  end

  assign count_o = cnt_reg;

endmodule

// File: rtl/mrv1_csrf_mt.sv
// Per-thread machine-mode CSR file: banked trap CSRs, shared mcycle, banked minstret,
// CSR read-modify-write, trap entry / mret updates and trap vector generation.
module mrv1_csrf_mt
  import mrv1_csrf_mt_pkg::*;
#(
  parameter int                      DATA_WIDTH_P  = 32,
  parameter int                      NUM_THREADS_P = 4,
  parameter logic [DATA_WIDTH_P-1:0] MTVEC_RESET_P = '0,
  localparam int                     TID_WIDTH_LP  = $clog2(NUM_THREADS_P)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  mrv1_csrf_mt_if.slave            csr,
  input  logic                     retire_i,
  input  logic [TID_WIDTH_LP-1:0]  retire_tid_i,
  input  logic                     trap_valid_i,
  input  logic [TID_WIDTH_LP-1:0]  trap_tid_i,
  input  logic [DATA_WIDTH_P-1:0]  trap_cause_i,
  input  logic [DATA_WIDTH_P-1:0]  trap_pc_i,
  output logic [DATA_WIDTH_P-1:0]  trap_vector_o,
  input  logic                     mret_i,
  input  logic [TID_WIDTH_LP-1:0]  mret_tid_i,
  output logic [DATA_WIDTH_P-1:0]  mepc_o,
  output logic [NUM_THREADS_P-1:0] irq_en_o
);

  localparam int DW = DATA_WIDTH_P;
  localparam int NT = NUM_THREADS_P;

  logic          mie_reg      [NT];
  logic          mie_next     [NT];
  logic          mpie_reg     [NT];
  logic          mpie_next    [NT];
  logic [DW-1:0] mtvec_reg    [NT];
  logic [DW-1:0] mtvec_next   [NT];
  logic [DW-1:0] mscratch_reg [NT];
  logic [DW-1:0] mscratch_next[NT];
  logic [DW-1:0] mepc_reg     [NT];
  logic [DW-1:0] mepc_next    [NT];
  logic [DW-1:0] mcause_reg   [NT];
  logic [DW-1:0] mcause_next  [NT];

  logic [63:0]   mcycle_cnt;
  logic [63:0]   minstret_cnt [NT];
  logic [DW-1:0] csr_old;
  logic [DW-1:0] csr_wval;
  logic          csr_known;
  logic          csr_we;
  logic [NT-1:0] csr_hit;
  logic [NT-1:0] trap_hit;
  logic [NT-1:0] mret_hit;

  always_comb begin
    csr_old   = '0;
    csr_known = 1'b1;
    case (csr.addr)
      CSR_MSTATUS: begin
        csr_old[12:11]            = 2'b11;
        csr_old[MSTATUS_MPIE_BIT] = mpie_reg[csr.tid];
        csr_old[MSTATUS_MIE_BIT]  = mie_reg[csr.tid];
      end
      CSR_MTVEC:               csr_old = mtvec_reg[csr.tid];
      CSR_MSCRATCH:            csr_old = mscratch_reg[csr.tid];
      CSR_MEPC:                csr_old = mepc_reg[csr.tid];
      CSR_MCAUSE:              csr_old = mcause_reg[csr.tid];
      CSR_MCYCLE, CSR_CYCLE:   csr_old = mcycle_cnt[DW-1:0];
      CSR_MINSTRET, CSR_INSTRET: csr_old = minstret_cnt[csr.tid][DW-1:0];
      // High halves only exist on a 32-bit datapath.
      CSR_MCYCLEH, CSR_CYCLEH: begin
        if (DW == 32) csr_old = DW'(mcycle_cnt[63:32]);
        else          csr_known = 1'b0;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        if (DW == 32) csr_old = DW'(minstret_cnt[csr.tid][63:32]);
        else          csr_known = 1'b0;
      end
      CSR_MHARTID:             csr_old = DW'(csr.tid);
      default:                 csr_known = 1'b0;
    endcase
  end

  assign csr.r_data  = csr_old;
  assign csr.illegal = !csr_known || (csr_is_read_only(csr.addr) && csr.op != CSR_OP_READ);
  assign csr_we      = !csr.illegal && csr.op != CSR_OP_READ;

  always_comb begin
    case (csr.op)
      CSR_OP_WRITE: csr_wval = csr.w_data;
      CSR_OP_SET:   csr_wval = csr_old | csr.w_data;
      CSR_OP_CLEAR: csr_wval = csr_old & ~csr.w_data;
      default:      csr_wval = csr_old;
    endcase
  end

  mrv1_csrf_mt_cnt64 #(.DATA_WIDTH_P(DW)) u_mcycle (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (1'b1),
    .wr_lo_i  (csr_we && csr.addr == CSR_MCYCLE),
    .wr_hi_i  (csr_we && csr.addr == CSR_MCYCLEH),
    .w_data_i (csr_wval),
    .count_o  (mcycle_cnt)
  );

  for (genvar gi = 0; gi < NT; gi++) begin : g_thread
    assign csr_hit[gi]  = csr_we && (csr.tid == TID_WIDTH_LP'(gi));
    assign trap_hit[gi] = trap_valid_i && (trap_tid_i == TID_WIDTH_LP'(gi));
    assign mret_hit[gi] = mret_i && (mret_tid_i == TID_WIDTH_LP'(gi));
    assign irq_en_o[gi] = mie_reg[gi];

    mrv1_csrf_mt_cnt64 #(.DATA_WIDTH_P(DW)) u_minstret (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .inc_i    (retire_i && (retire_tid_i == TID_WIDTH_LP'(gi))),
      .wr_lo_i  (csr_hit[gi] && csr.addr == CSR_MINSTRET),
      .wr_hi_i  (csr_hit[gi] && csr.addr == CSR_MINSTRETH),
      .w_data_i (csr_wval),
      .count_o  (minstret_cnt[gi])
    );
  end

  // Per thread: trap beats mret beats a CSR write to mstatus/mepc/mcause.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      mie_next[t]      = mie_reg[t];
      mpie_next[t]     = mpie_reg[t];
      mtvec_next[t]    = mtvec_reg[t];
      mscratch_next[t] = mscratch_reg[t];
      mepc_next[t]     = mepc_reg[t];
      mcause_next[t]   = mcause_reg[t];
      if (trap_hit[t]) begin
        mepc_next[t]   = trap_pc_i & ~DW'(3);
        mcause_next[t] = trap_cause_i;
        mpie_next[t]   = mie_reg[t];
        mie_next[t]    = 1'b0;
      end else if (mret_hit[t]) begin
        mie_next[t]  = mpie_reg[t];
        mpie_next[t] = 1'b1;
      end else if (csr_hit[t]) begin
        case (csr.addr)
          CSR_MSTATUS: begin
            mie_next[t]  = csr_wval[MSTATUS_MIE_BIT];
            mpie_next[t] = csr_wval[MSTATUS_MPIE_BIT];
          end
          CSR_MEPC:   mepc_next[t]   = csr_wval & ~DW'(3);
          CSR_MCAUSE: mcause_next[t] = csr_wval;
          default: ;
        endcase
      end
      // Reserved vector modes 2/3 collapse to direct mode.
      if (csr_hit[t] && csr.addr == CSR_MTVEC)
        mtvec_next[t] = csr_wval[1] ? (csr_wval & ~DW'(3)) : csr_wval;
      if (csr_hit[t] && csr.addr == CSR_MSCRATCH)
        mscratch_next[t] = csr_wval;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < NT; t++) begin
        mie_reg[t]      <= 1'b0;
        mpie_reg[t]     <= 1'b0;
        mtvec_reg[t]    <= MTVEC_RESET_P;
        mscratch_reg[t] <= '0;
        mepc_reg[t]     <= '0;
        mcause_reg[t]   <= '0;
      end
    end else begin
      for (int t = 0; t < NT; t++) begin
        mie_reg[t]      <= mie_next[t];
        mpie_reg[t]     <= mpie_next[t];
        mtvec_reg[t]    <= mtvec_next[t];
        mscratch_reg[t] <= mscratch_next[t];
        mepc_reg[t]     <= mepc_next[t];
        mcause_reg[t]   <= mcause_next[t];
      end
    end
  end

  always_comb begin
    trap_vector_o = mtvec_reg[trap_tid_i] & ~DW'(3);
    if (mtvec_reg[trap_tid_i][1:0] == 2'b01 && trap_cause_i[DW-1])
      trap_vector_o = trap_vector_o + DW'({trap_cause_i[DW-2:0], 2'b00});
  end

  assign mepc_o = mepc_reg[mret_tid_i];

endmodule
